// File: rtl/mac_sequencer.sv
// mac_sequencer: sequences one neuron's multiply-accumulate pass over x/w memories.
// Ports: clk, rst (async active-low); start/n_inputs/base_addr request a pass;
// rd_en/rd_addr read both memories, x_rdata/w_rdata return one cycle later;
// zin is the registered signed product for the external accumulator, acc_rst
// clears it; busy is high outside IDLE, done pulses when the sum is final.
module mac_sequencer #(
    parameter int N_MAX = 16,
    parameter int AW    = 8,
    parameter int CW    = $clog2(N_MAX + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [CW-1:0]      n_inputs,
    input  logic [AW-1:0]      base_addr,
    output logic               rd_en,
    output logic [AW-1:0]      rd_addr,
    input  logic signed [7:0]  x_rdata,
    input  logic signed [7:0]  w_rdata,
    output logic signed [15:0] zin,
    output logic               acc_rst,
    output logic               busy,
    output logic               done
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] CLEAR = 3'd1;
    localparam logic [2:0] FETCH = 3'd2;
    localparam logic [2:0] DRAIN = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    logic [2:0]          state, nxt;
    logic [CW-1:0]       n_q, k, n_sat;
    logic                v1;
    logic signed [15:0]  prod;

    assign n_sat = (n_inputs > CW'(N_MAX)) ? CW'(N_MAX) : n_inputs;
    assign prod  = x_rdata * w_rdata;

    // k counts cycles within FETCH (issue index) and within DRAIN
    always_comb begin
        nxt = (state == IDLE)  ? (start ? CLEAR : IDLE) :
              (state == CLEAR) ? ((n_q == '0) ? DONE : FETCH) :
              (state == FETCH) ? ((k == n_q - CW'(1)) ? DRAIN : FETCH) :
              (state == DRAIN) ? ((k == CW'(1)) ? DONE : DRAIN) :
                                 IDLE;
    end

    // outputs are registered from the next state so they align with it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            n_q     <= '0;
            k       <= '0;
            rd_en   <= 1'b0;
            rd_addr <= '0;
            v1      <= 1'b0;
            zin     <= '0;
            acc_rst <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= nxt;
            k       <= (state != nxt) ? '0 : k + CW'(1);
            busy    <= nxt != IDLE;
            acc_rst <= nxt == CLEAR;
            done    <= nxt == DONE;
            rd_en   <= nxt == FETCH;
            if (state == IDLE && start) begin
                n_q     <= n_sat;
                rd_addr <= base_addr;
            end
            if (state == FETCH && nxt == FETCH)
                rd_addr <= rd_addr + AW'(1);
            v1  <= rd_en;
            zin <= v1 ? prod : 16'sd0;
        end
    end
endmodule
